// File: rtl/fo_phase_gen.sv
// Frequency-offset phase generator: leaky-averages sparse FO estimates and emits
// a per-block base phase and per-sample phase step for the derotator, with lock detect.
module fo_phase_gen #(
  parameter int unsigned NBW_FO   = 15,
  parameter int unsigned NBW_PH   = 20,
  parameter int unsigned NBF_AVG  = 7,
  parameter int unsigned FE_NS_IN = 64
) (
  input  logic                     clk,
  input  logic                     rst_sync,
  input  logic                     i_enable,
  input  logic                     i_fo_valid,
  input  logic signed [NBW_FO-1:0] i_fo_value,
  input  logic                     i_hold,
  input  logic [2:0]               i_alpha_shift,
  input  logic [NBW_FO-2:0]        i_lock_thr,
  input  logic [3:0]               i_lock_cnt,
  input  logic                     i_valid,
  output logic                     o_valid,
  output logic [NBW_PH-1:0]        o_phase_base,
  output logic [NBW_PH-1:0]        o_phase_step,
  output logic                     o_locked
);

  localparam int unsigned NBW_AVG = NBW_FO + NBF_AVG;
  localparam int unsigned NBW_DIF = NBW_AVG + 1;
  localparam int unsigned LOG2_NS = $clog2(FE_NS_IN);
  localparam int unsigned NBW_CNT = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_TRACK} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;
  logic                      w_load;
  logic                      w_update;
  logic                      w_clear;

  logic signed [NBW_AVG-1:0] r_avg;
  logic [NBW_PH-1:0]         r_phase;
  logic [NBW_CNT-1:0]        r_cnt;

  logic signed [NBW_FO-1:0]  w_step;
  logic [NBW_PH-1:0]         w_step_ext;
  logic [NBW_PH-1:0]         w_phase_adv;
  logic signed [NBW_AVG-1:0] w_fo_scaled;
  logic signed [NBW_DIF-1:0] w_diff;
  logic signed [NBW_DIF-1:0] w_delta;
  logic signed [NBW_DIF-1:0] w_sum;
  logic [2:0]                w_shamt;
  logic signed [NBW_FO:0]    w_err;
  logic [NBW_FO:0]           w_abs;
  logic                      w_in_thr;
  logic [NBW_CNT-1:0]        w_cnt_tgt;
  logic [NBW_CNT-1:0]        w_cnt_inc;

  always_ff @(posedge clk) begin
    if (rst_sync) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_ACQ;
        ST_ACQ:   if (w_accept) w_state_nxt = ST_TRACK;
        ST_TRACK: w_state_nxt = ST_TRACK;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control decode: disable wins over any estimate arriving the same cycle
  always_comb begin
    w_clear  = !i_enable;
    w_accept = i_enable && i_fo_valid && !i_hold && (r_state != ST_IDLE);
    w_load   = w_accept && (r_state == ST_ACQ);
    w_update = w_accept && (r_state == ST_TRACK);
  end

  always_comb begin
    w_step      = (r_state == ST_TRACK) ? r_avg[NBW_AVG-1:NBF_AVG] : '0;
    w_step_ext  = {{(NBW_PH-NBW_FO){w_step[NBW_FO-1]}}, w_step};
    w_phase_adv = w_step_ext << LOG2_NS;

    w_fo_scaled = {i_fo_value, {NBF_AVG{1'b0}}};
    w_shamt     = (32'(i_alpha_shift) > NBF_AVG) ? 3'(NBF_AVG) : i_alpha_shift;
    w_diff      = $signed({w_fo_scaled[NBW_AVG-1], w_fo_scaled})
                - $signed({r_avg[NBW_AVG-1], r_avg});
    w_delta     = w_diff >>> w_shamt;
    w_sum       = $signed({r_avg[NBW_AVG-1], r_avg}) + w_delta;

    w_err       = $signed({i_fo_value[NBW_FO-1], i_fo_value})
                - $signed({w_step[NBW_FO-1], w_step});
    w_abs       = w_err[NBW_FO] ? $unsigned(-w_err) : $unsigned(w_err);
    w_in_thr    = (w_abs <= {2'b00, i_lock_thr});
    w_cnt_tgt   = (i_lock_cnt == '0) ? NBW_CNT'(1) : i_lock_cnt;
    w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + NBW_CNT'(1);
  end

  // Leaky average and lock counter; the sum always lands between avg and target so truncation is exact
  always_ff @(posedge clk) begin
    if (rst_sync || w_clear) begin
      r_avg    <= '0;
      r_cnt    <= '0;
      o_locked <= 1'b0;
    end else if (w_load) begin
      r_avg    <= w_fo_scaled;
      r_cnt    <= NBW_CNT'(1);
      o_locked <= (w_cnt_tgt == NBW_CNT'(1));
    end else if (w_update) begin
      r_avg <= w_sum[NBW_AVG-1:0];
      if (w_in_thr) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc >= w_cnt_tgt) o_locked <= 1'b1;
      end else begin
        r_cnt    <= '0;
        o_locked <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync || w_clear) r_phase <= '0;
    else if (i_valid)        r_phase <= r_phase + w_phase_adv;
  end

  // A block arriving with the disable still sees pre-clear phase and step
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      o_valid      <= 1'b0;
      o_phase_base <= '0;
      o_phase_step <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_phase_base <= r_phase;
        o_phase_step <= w_step_ext;
      end else if (w_clear) begin
        o_phase_base <= '0;
        o_phase_step <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fo_phase_gen.sv
// Directed bench for fo_phase_gen with hand-computed phase, step and lock expectations.
module tb_fo_phase_gen;

  logic               clk;
  logic               rst_sync;
  logic               i_enable;
  logic               i_fo_valid;
  logic signed [14:0] i_fo_value;
  logic               i_hold;
  logic [2:0]         i_alpha_shift;
  logic [13:0]        i_lock_thr;
  logic [3:0]         i_lock_cnt;
  logic               i_valid;
  logic               o_valid;
  logic [19:0]        o_phase_base;
  logic [19:0]        o_phase_step;
  logic               o_locked;

  int n_checks;
  int n_fail;

  fo_phase_gen dut (
    .clk           (clk),
    .rst_sync      (rst_sync),
    .i_enable      (i_enable),
    .i_fo_valid    (i_fo_valid),
    .i_fo_value    (i_fo_value),
    .i_hold        (i_hold),
    .i_alpha_shift (i_alpha_shift),
    .i_lock_thr    (i_lock_thr),
    .i_lock_cnt    (i_lock_cnt),
    .i_valid       (i_valid),
    .o_valid       (o_valid),
    .o_phase_base  (o_phase_base),
    .o_phase_step  (o_phase_step),
    .o_locked      (o_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [19:0] base,
                         input logic [19:0] stp);
    chk_eq({tag, "_valid"}, 32'(o_valid), 32'(vld));
    chk_eq({tag, "_base"}, 32'(o_phase_base), 32'(base));
    chk_eq({tag, "_step"}, 32'(o_phase_step), 32'(stp));
  endtask

  task automatic blk(input string tag, input logic [19:0] base, input logic [19:0] stp);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk_out(tag, 1'b1, base, stp);
  endtask

  task automatic send_fo(input logic signed [14:0] v);
    i_fo_valid = 1'b1;
    i_fo_value = v;
    tick();
    i_fo_valid = 1'b0;
  endtask

  // Disable for one cycle then enable: state returns to ACQ with everything cleared
  task automatic restart();
    i_enable   = 1'b0;
    i_valid    = 1'b0;
    i_fo_valid = 1'b0;
    i_hold     = 1'b0;
    tick();
    i_enable = 1'b1;
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_sync      = 1'b1;
    i_enable      = 1'b0;
    i_fo_valid    = 1'b0;
    i_fo_value    = '0;
    i_hold        = 1'b0;
    i_alpha_shift = 3'd0;
    i_lock_thr    = 14'd16;
    i_lock_cnt    = 4'd4;
    i_valid       = 1'b0;
    tick();
    tick();
    chk_out("rst", 1'b0, 20'd0, 20'd0);
    chk_eq("rst_locked", 32'(o_locked), 32'd0);
    rst_sync = 1'b0;

    // Direct load, continuous blocks
    restart();
    blk("acq", 20'd0, 20'd0);
    send_fo(15'sd100);
    i_valid = 1'b1;
    tick(); chk_out("fo100_b0", 1'b1, 20'd0, 20'd100);
    tick(); chk_out("fo100_b1", 1'b1, 20'd6400, 20'd100);
    tick(); chk_out("fo100_b2", 1'b1, 20'd12800, 20'd100);
    i_valid = 1'b0;
    tick(); chk_eq("fo100_idle_valid", 32'(o_valid), 32'd0);
    chk_eq("fo100_hold_base", 32'(o_phase_base), 32'd12800);

    // Positive wrap at max estimate
    restart();
    send_fo(15'sd16383);
    i_valid = 1'b1;
    tick(); chk_out("wrap_b0", 1'b1, 20'd0, 20'd16383);
    tick(); chk_out("wrap_b1", 1'b1, 20'd1048512, 20'd16383);
    tick(); chk_out("wrap_b2", 1'b1, 20'd1048448, 20'd16383);
    i_valid = 1'b0;

    // Negative step wraps downward
    restart();
    send_fo(-15'sd5);
    blk("neg_b0", 20'd0, 20'hFFFFB);
    blk("neg_b1", 20'd1048256, 20'hFFFFB);

    // Smoothing with alpha=1
    restart();
    i_alpha_shift = 3'd1;
    send_fo(15'sd1000);
    blk("sm_1000", 20'd0, 20'd1000);
    send_fo(15'sd0);
    blk("sm_500", 20'd64000, 20'd500);
    send_fo(15'sd0);
    blk("sm_250", 20'd96000, 20'd250);
    i_alpha_shift = 3'd0;

    // Lock acquisition, hold freeze, loss of lock
    restart();
    send_fo(15'sd200); chk_eq("lk_1", 32'(o_locked), 32'd0);
    send_fo(15'sd205); chk_eq("lk_2", 32'(o_locked), 32'd0);
    send_fo(15'sd198); chk_eq("lk_3", 32'(o_locked), 32'd0);
    send_fo(15'sd210); chk_eq("lk_4", 32'(o_locked), 32'd1);
    i_hold = 1'b1;
    send_fo(15'sd900); chk_eq("lk_hold", 32'(o_locked), 32'd1);
    i_hold = 1'b0;
    blk("lk_hold_step", 20'd0, 20'd210);
    send_fo(15'sd300); chk_eq("lk_lost", 32'(o_locked), 32'd0);
    blk("lk_lost_step", 20'd13440, 20'd300);

    // Lock count 0 behaves as 1
    restart();
    i_lock_cnt = 4'd0;
    send_fo(15'sd50); chk_eq("lk_cnt0", 32'(o_locked), 32'd1);
    i_lock_cnt = 4'd4;

    // Simultaneous estimate and block: old step first, new step next
    restart();
    send_fo(15'sd100);
    i_fo_valid = 1'b1;
    i_fo_value = 15'sd200;
    i_valid    = 1'b1;
    tick();
    i_fo_valid = 1'b0;
    chk_out("sim_old", 1'b1, 20'd0, 20'd100);
    tick(); chk_out("sim_new", 1'b1, 20'd6400, 20'd200);

    // Disable coincident with a block: pre-clear output, then all zero
    i_enable = 1'b0;
    tick(); chk_out("dis_last", 1'b1, 20'd19200, 20'd200);
    chk_eq("dis_locked", 32'(o_locked), 32'd0);
    i_valid = 1'b0;
    tick(); chk_out("dis_clr", 1'b0, 20'd0, 20'd0);
    i_enable = 1'b1;
    tick();
    blk("reen_acq", 20'd0, 20'd0);

    // Mid-stream reset drops the in-flight output
    restart();
    send_fo(15'sd100);
    i_valid = 1'b1;
    tick(); chk_out("rs_pre", 1'b1, 20'd0, 20'd100);
    rst_sync = 1'b1;
    tick(); chk_out("rs_mid", 1'b0, 20'd0, 20'd0);
    chk_eq("rs_locked", 32'(o_locked), 32'd0);
    rst_sync = 1'b0;
    i_valid  = 1'b0;
    tick();
    blk("rs_acq", 20'd0, 20'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
